reg_cmd_master: RTL and testbench
=================================

// Module: reg_cmd_master
// PURPOSE
// Initiator side of the register-access byte protocol: turns a parallel register
// read/write request into the 8-byte command stream (magic, type, addr[2], data[4], LSB
// first) and collects the 4-byte reply plus the end marker from the responder.
// Sits between a local sequencer/test harness and the byte FIFO link to the register
// manager; one transaction in flight at a time.
// PARAMETERS
// MAGIC        8'hAA   first byte of every command
// TIMEOUT      16'hFFFF  max idle cycles waiting for any reply byte or end marker
// PORTS
// clk          in   1   system clock
// reset        in   1   synchronous, active-high reset
// req_valid    in   1   request present
// req_ready    out  1   block idle; request accepted when req_valid && req_ready
// req_wr       in   1   1 = register write, 0 = read
// req_addr     in   16  register address
// req_data     in   32  write data (ignored for reads)
// cmd_out      out  8   command byte to link
// cmd_wr       out  1   cmd_out valid this cycle (one byte per asserted cycle)
// cmd_full     in   1   link cannot take a byte; cmd_wr must stay low while high
// reply_in     in   8   reply byte from responder
// reply_rdy    in   1   reply_in valid
// reply_ack    out  1   consume reply_in this cycle
// reply_end    in   1   end-of-reply marker (single-cycle pulse)
// rsp_valid    out  1   one-cycle pulse: transaction finished
// rsp_data     out  32  reply word (register value), held until next rsp_valid
// rsp_err      out  1   qualifies rsp_valid: timeout or protocol error
// BEHAVIOUR
// - Reset (sync, any state): state=IDLE, req_ready=1, cmd_wr=0, cmd_out=0, reply_ack=0,
//   rsp_valid=0, rsp_data=0, rsp_err=0, byte index/timer cleared; transaction dropped.
// - All outputs registered except req_ready (= state==IDLE, combinational from state).
// - States: IDLE -> SEND -> RECV -> ENDW -> DONE -> IDLE.
// - IDLE: on req_valid, latch wr/addr/data (reads latch data=0), idx=0, go SEND.
// - SEND: byte sequence idx0..7 = MAGIC, {7'b0,wr}, addr[7:0], addr[15:8], data[7:0],
//   data[15:8], data[23:16], data[31:24]. Per cycle: if !cmd_full drive cmd_wr=1 with
//   byte idx, idx++; else cmd_wr=0, idx held. First cmd_wr is cycle after acceptance
//   at earliest. After byte 7 issued go RECV, idx=0, timer=0.
// - RECV: reply_ack = reply_rdy (same cycle, combinational-free: registered ack issued
//   only when reply_rdy seen and previous cycle not acked, i.e. one ack per responder
//   step; byte captured on the ack cycle into rsp_data[8*idx+:8]). After 4th ack go ENDW.
//   reply_end seen before 4 bytes -> DONE with err=1.
// - ENDW: reply_end -> DONE err=0. reply_rdy here ignored (not acked).
// - Timer: resets on every ack and on entry to RECV/ENDW; counts otherwise; reaching
//   TIMEOUT in RECV or ENDW -> DONE with err=1, rsp_data holds bytes captured so far.
// - DONE: rsp_valid=1, rsp_err=err for exactly one cycle; next cycle IDLE.
// - Write transactions still wait for the 4-byte reply (responder echoes register).
// - cmd_full rising mid-command stalls only; no byte dropped or repeated.
// - req_valid while not IDLE ignored (req_ready=0). Back-to-back: new request may be
//   accepted the cycle after rsp_valid.
// TESTING
// - Write addr 16'h0012 data 32'hDEADBEEF, cmd_full=0 -> cmd_out AA,01,12,00,EF,BE,AD,DE
//   on 8 consecutive cmd_wr cycles; responder replies EF,BE,AD,DE + end -> rsp_valid,
//   rsp_data=32'hDEADBEEF, rsp_err=0.
// - Read addr 16'h0304 -> bytes AA,00,04,03,00,00,00,00; reply 78,56,34,12 + end ->
//   rsp_data=32'h12345678, rsp_err=0.
// - cmd_full high on bytes 2 and 5 for 3 cycles each -> same 8-byte order, no cmd_wr
//   while full, total 14 cycles from first to last byte.
// - Responder sends 2 reply bytes then silence, TIMEOUT=16 -> rsp_valid with rsp_err=1
//   17 cycles after 2nd ack, rsp_data[15:0] = captured bytes.
// - reply_end after 3 bytes -> rsp_err=1; 4 bytes then no end for TIMEOUT -> rsp_err=1.
// - reset asserted during SEND byte 4 -> next cycle req_ready=1, cmd_wr=0; new request
//   starts with MAGIC.

Source files
------------

// File: rtl/reg_cmd_master.sv
// Register-access initiator: serialises one register request into the 8-byte command frame
// and collects the 4-byte reply plus end marker from the responder.
module reg_cmd_master #(
  parameter logic [7:0]  MAGIC   = 8'hAA,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [31:0] req_data,
  output logic [7:0]  cmd_out,
  output logic        cmd_wr,
  input  logic        cmd_full,
  input  logic [7:0]  reply_in,
  input  logic        reply_rdy,
  output logic        reply_ack,
  input  logic        reply_end,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_err
);

  typedef enum logic [2:0] {StIdle, StSend, StRecv, StEndw, StDone} state_e;

  state_e      state_q;
  logic        wr_q;
  logic [15:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  idx_q;
  logic [15:0] timer_q;
  logic [31:0] rx_q;

  logic [63:0] frame;
  logic [7:0]  send_byte;
  logic        timed_out;

  // Frame bytes in wire order, byte 0 in the low lane.
  assign frame     = {data_q, addr_q, 7'b0, wr_q, MAGIC};
  assign send_byte = frame[{idx_q, 3'b000} +: 8];
  assign timed_out = (timer_q == TIMEOUT);
  assign req_ready = (state_q == StIdle);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      idx_q     <= '0;
      timer_q   <= '0;
      rx_q      <= '0;
      cmd_out   <= '0;
      cmd_wr    <= 1'b0;
      reply_ack <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      cmd_wr    <= 1'b0;
      reply_ack <= 1'b0;
      rsp_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            data_q  <= req_wr ? req_data : 32'h0;
            idx_q   <= '0;
            rx_q    <= '0;
            state_q <= StSend;
          end
        end
        StSend: begin
          if (!cmd_full) begin
            cmd_wr  <= 1'b1;
            cmd_out <= send_byte;
            idx_q   <= idx_q + 3'd1;
            if (idx_q == 3'd7) begin
              idx_q   <= '0;
              timer_q <= '0;
              state_q <= StRecv;
            end
          end
        end
        StRecv: begin
          if (reply_end) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= rx_q;
          end else if (reply_rdy && !reply_ack) begin
            // At most one ack per responder step: a byte still held after an ack is not re-taken.
            reply_ack                        <= 1'b1;
            rx_q[{idx_q[1:0], 3'b000} +: 8] <= reply_in;
            timer_q                          <= '0;
            idx_q                            <= idx_q + 3'd1;
            if (idx_q == 3'd3) state_q <= StEndw;
          end else if (timed_out) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_data  <= rx_q;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        StEndw: begin
          if (reply_end || timed_out) begin
            state_q   <= StDone;
            rsp_valid <= 1'b1;
            rsp_err   <= !reply_end;
            rsp_data  <= rx_q;
          end else begin
            timer_q <= timer_q + 16'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_cmd_master.sv
// Randomised bench for reg_cmd_master: command framing, reply collection, stalls, timeouts,
// early end markers and mid-command reset, checked against a frame-level reference model.
module tb_reg_cmd_master;

  localparam logic [7:0]  MAGIC   = 8'hAA;
  localparam logic [15:0] TIMEOUT = 16'd16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [15:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [7:0]  cmd_out;
  logic        cmd_wr;
  logic        cmd_full = 1'b0;
  logic [7:0]  reply_in = '0;
  logic        reply_rdy = 1'b0;
  logic        reply_ack;
  logic        reply_end = 1'b0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  reg_cmd_master #(.MAGIC(MAGIC), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .cmd_out   (cmd_out),
    .cmd_wr    (cmd_wr),
    .cmd_full  (cmd_full),
    .reply_in  (reply_in),
    .reply_rdy (reply_rdy),
    .reply_ack (reply_ack),
    .reply_end (reply_end),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Passive observation of DUT outputs, sampled on the falling edge.
  int          cyc = 0;
  logic        full_at_edge = 1'b0;
  logic [7:0]  got_cmd[$];
  int          wr_cyc_q[$];
  int          viol = 0;
  int          ack_cnt = 0;
  int          last_ack_cyc = 0;
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  logic        rsp_err_s = 1'b0;
  logic [31:0] rsp_data_s = '0;
  logic        prev_rsp = 1'b0;
  logic        ready_after = 1'b0;

  always @(posedge clk) begin
    cyc          <= cyc + 1;
    full_at_edge <= cmd_full;
  end

  always @(negedge clk) begin
    prev_rsp <= rsp_valid;
    if (prev_rsp) ready_after <= req_ready;
    if (cmd_wr) begin
      got_cmd.push_back(cmd_out);
      wr_cyc_q.push_back(cyc);
      if (full_at_edge) viol <= viol + 1;
    end
    if (reply_ack) begin
      ack_cnt      <= ack_cnt + 1;
      last_ack_cyc <= cyc;
    end
    if (rsp_valid) begin
      rsp_cnt    <= rsp_cnt + 1;
      rsp_cyc    <= cyc;
      rsp_err_s  <= rsp_err;
      rsp_data_s <= rsp_data;
    end
  end

  task automatic send_req(input bit wr, input logic [15:0] addr, input logic [31:0] data);
    int w = 0;
    while (!req_ready && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    check_eq("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = addr;
    req_data  = data;
    @(negedge clk); #1;
    check_eq("ready_busy", req_ready, 0);
    // A request presented while busy must be ignored.
    req_wr   = 1'($urandom);
    req_addr = 16'($urandom);
    req_data = $urandom;
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  // mode 0: link never full; 1: stall 3 cycles before bytes 2 and 5; 2: random stalls.
  task automatic drive_full(input int mode);
    int cnt = 0;
    int stall = 0;
    int guard = 0;
    while (cnt < 8 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (cmd_wr) begin
        cnt++;
        if (mode == 1 && (cnt == 2 || cnt == 5)) stall = 3;
      end
      if (mode == 2) begin
        cmd_full = ($urandom_range(0, 3) == 0);
      end else begin
        cmd_full = (stall != 0);
        if (stall != 0) stall--;
      end
    end
    cmd_full = 1'b0;
    if (cnt != 8) check_eq("cmd_bytes_seen", cnt, 8);
  endtask

  task automatic respond(input logic [31:0] word, input int n, input bit send_end,
                         input bit stray, output int end_cyc);
    int w;
    end_cyc = -1;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      reply_in  = word[8*i +: 8];
      reply_rdy = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!reply_ack && w < 64);
      if (!reply_ack) check_eq("ack_wait", reply_ack, 1);
      reply_rdy = 1'b0;
      reply_in  = 8'($urandom);
    end
    if (stray) begin
      reply_rdy = 1'b1;
      repeat (2) @(negedge clk);
      reply_rdy = 1'b0;
    end
    if (send_end) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      end_cyc   = cyc;
      reply_end = 1'b1;
      @(negedge clk);
      reply_end = 1'b0;
    end
  endtask

  task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [31:0] data,
                         input logic [31:0] word, input int n, input bit send_end,
                         input int mode, input bit stray);
    int          cb = got_cmd.size();
    int          ab = ack_cnt;
    int          rb = rsp_cnt;
    int          vb = viol;
    int          end_cyc;
    int          ref_cyc;
    int          w = 0;
    logic [31:0] dd;
    logic [31:0] mask = '0;
    logic [7:0]  exp_cmd[8];
    logic        exp_err;

    dd         = wr ? data : 32'h0;
    exp_cmd[0] = MAGIC;
    exp_cmd[1] = {7'b0, wr};
    exp_cmd[2] = addr[7:0];
    exp_cmd[3] = addr[15:8];
    for (int i = 0; i < 4; i++) exp_cmd[4+i] = dd[8*i +: 8];
    for (int i = 0; i < n; i++) mask[8*i +: 8] = 8'hFF;
    exp_err = !(n == 4 && send_end);

    fork
      send_req(wr, addr, data);
      drive_full(mode);
    join
    respond(word, n, send_end, stray, end_cyc);
    while (rsp_cnt == rb && w < 200) begin
      @(negedge clk); #1;
      w++;
    end
    check_eq("rsp_seen", 32'(rsp_cnt != rb), 1);

    check_eq("cmd_count", got_cmd.size() - cb, 8);
    if (got_cmd.size() >= cb + 8) begin
      for (int i = 0; i < 8; i++)
        check_eq($sformatf("cmd_byte%0d", i), got_cmd[cb+i], exp_cmd[i]);
      if (mode == 1) check_eq("stall_span", wr_cyc_q[cb+7] - wr_cyc_q[cb], 13);
      if (!send_end) begin
        ref_cyc = (n > 0) ? last_ack_cyc : wr_cyc_q[cb+7];
        check_eq("timeout_latency", rsp_cyc - ref_cyc, 32'(TIMEOUT) + 1);
      end
    end
    if (send_end) check_eq("end_to_rsp", rsp_cyc - end_cyc, 1);
    check_eq("wr_while_full", viol - vb, 0);
    check_eq("ack_count", ack_cnt - ab, n);
    check_eq("rsp_err", rsp_err_s, exp_err);
    check_eq("rsp_data", rsp_data_s & mask, word & mask);

    @(negedge clk); #1;
    check_eq("ready_after_rsp", ready_after, 1);
    check_eq("rsp_pulses", rsp_cnt - rb, 1);
    check_eq("rsp_hold", rsp_data & mask, word & mask);
  endtask

  task automatic reset_mid();
    fork
      send_req(1'b1, 16'h00AB, 32'hCAFE_F00D);
      begin
        int cnt = 0;
        int g = 0;
        while (cnt < 4 && g < 100) begin
          @(negedge clk);
          g++;
          if (cmd_wr) cnt++;
        end
        reset = 1'b1;
      end
    join
    @(negedge clk); #1;
    check_eq("rst_mid_ready", req_ready, 1);
    check_eq("rst_mid_cmd_wr", cmd_wr, 0);
    check_eq("rst_mid_cmd_out", cmd_out, 0);
    check_eq("rst_mid_rsp_data", rsp_data, 0);
    check_eq("rst_mid_ack", reply_ack, 0);
    reset = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit          wr;
    int          n;
    int          sel;
    bit          send_end;
    logic [31:0] word;

    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_cmd_wr", cmd_wr, 0);
    check_eq("rst_cmd_out", cmd_out, 0);
    check_eq("rst_ack", reply_ack, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rsp_data", rsp_data, 0);
    reset = 1'b0;
    @(negedge clk); #1;

    run_txn(1'b1, 16'h0012, 32'hDEADBEEF, 32'hDEADBEEF, 4, 1'b1, 0, 1'b0);
    run_txn(1'b0, 16'h0304, 32'h5555AAAA, 32'h12345678, 4, 1'b1, 0, 1'b1);
    run_txn(1'b1, 16'hBEEF, 32'h0BAD_F00D, 32'h0BAD_F00D, 4, 1'b1, 1, 1'b0);
    run_txn(1'b0, 16'h1000, 32'h0, 32'h0000_C3A5, 2, 1'b0, 0, 1'b0);
    run_txn(1'b0, 16'h2000, 32'h0, 32'h0077_6655, 3, 1'b1, 0, 1'b0);
    run_txn(1'b1, 16'h3000, 32'h89AB_CDEF, 32'h89AB_CDEF, 4, 1'b0, 0, 1'b1);
    reset_mid();
    run_txn(1'b1, 16'h4444, 32'h0102_0304, 32'h0102_0304, 4, 1'b1, 0, 1'b0);

    for (int t = 0; t < 20; t++) begin
      wr   = 1'($urandom);
      word = $urandom;
      sel  = $urandom_range(0, 7);
      if (sel == 5) begin
        n = $urandom_range(0, 3);
        send_end = 1'b1;
      end else if (sel == 6) begin
        n = $urandom_range(0, 4);
        send_end = 1'b0;
      end else begin
        n = 4;
        send_end = 1'b1;
      end
      run_txn(wr, 16'($urandom), $urandom, word, n, send_end, $urandom_range(0, 2),
              (n == 4) && ($urandom_range(0, 1) == 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
